// File: rtl/ring_phase_monitor.sv
// Watches the one-hot output of ring_counter: decodes the phase, checks left rotation,
// tracks lock/fault state, counts revolutions and (saturating) illegal transitions.
module ring_phase_monitor #(
   parameter int N        = 4,
   parameter int LOCK_CNT = 3,
   parameter int REV_W    = 8,
   parameter int ERR_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         count_in,
   input  logic                 clr_err,
   output logic [$clog2(N)-1:0] phase,
   output logic                 phase_vld,
   output logic                 wrap,
   output logic [REV_W-1:0]     rev_cnt,
   output logic                 locked,
   output logic                 fault,
   output logic [ERR_W-1:0]     err_cnt
);

   localparam int PW   = $clog2(N);
   localparam int GR_W = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {SYNC, LOCKED, FAULT} state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      prev_q, prev_d;
   logic              prev_ok_q, prev_ok_d;
   logic [GR_W-1:0]   good_run_q, good_run_d;
   logic [PW-1:0]     phase_q, phase_d;
   logic              phase_vld_q, phase_vld_d;
   logic              wrap_q, wrap_d;
   logic [REV_W-1:0]  rev_q, rev_d;
   logic [ERR_W-1:0]  err_q, err_d;

   logic              oh_ok;
   logic              legal;
   logic [PW-1:0]     phase_idx;
   logic [ERR_W-1:0]  err_base;
   logic [ERR_W-1:0]  err_inc;

   always_comb begin
      oh_ok     = (count_in != '0) && ((count_in & (count_in - N'(1))) == '0);
      legal     = oh_ok && prev_ok_q && (count_in == {prev_q[N-2:0], prev_q[N-1]});
      phase_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (count_in[i]) phase_idx = PW'(i);
      end
      // clr_err acts before any increment, so clear + illegal in LOCKED yields 1
      err_base = clr_err ? '0 : err_q;
      err_inc  = (err_base == '1) ? err_base : err_base + ERR_W'(1);
   end

   always_comb begin
      state_d     = state_q;
      good_run_d  = good_run_q;
      wrap_d      = 1'b0;
      rev_d       = rev_q;
      err_d       = err_base;
      prev_d      = count_in;
      prev_ok_d   = oh_ok;
      phase_d     = oh_ok ? phase_idx : phase_q;
      phase_vld_d = oh_ok;
      case (state_q)
         SYNC: begin
            if (legal) begin
               if (int'(good_run_q) + 1 >= LOCK_CNT) begin
                  state_d    = LOCKED;
                  good_run_d = '0;
               end else begin
                  good_run_d = good_run_q + GR_W'(1);
               end
            end else begin
               good_run_d = '0;
            end
         end
         LOCKED: begin
            if (legal) begin
               if (count_in[0]) begin
                  wrap_d = 1'b1;
                  rev_d  = rev_q + REV_W'(1);
               end
            end else begin
               state_d = FAULT;
               err_d   = err_inc;
            end
         end
         FAULT: begin
            if (clr_err) begin
               state_d    = SYNC;
               good_run_d = '0;
            end else if (!legal) begin
               err_d = err_inc;
            end
         end
         default: begin
            state_d    = SYNC;
            good_run_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= SYNC;
         prev_q      <= '0;
         prev_ok_q   <= 1'b0;
         good_run_q  <= '0;
         phase_q     <= '0;
         phase_vld_q <= 1'b0;
         wrap_q      <= 1'b0;
         rev_q       <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         prev_ok_q   <= prev_ok_d;
         good_run_q  <= good_run_d;
         phase_q     <= phase_d;
         phase_vld_q <= phase_vld_d;
         wrap_q      <= wrap_d;
         rev_q       <= rev_d;
         err_q       <= err_d;
      end
   end

   assign phase     = phase_q;
   assign phase_vld = phase_vld_q;
   assign wrap      = wrap_q;
   assign rev_cnt   = rev_q;
   assign locked    = (state_q == LOCKED);
   assign fault     = (state_q == FAULT);
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor (N=4, LOCK_CNT=3, REV_W=8, ERR_W=2) with a
// behavioural reference model feeding an expected-value scoreboard queue.
module tb_ring_phase_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] count_in;
   logic       clr_err;
   logic [1:0] phase;
   logic       phase_vld;
   logic       wrap;
   logic [7:0] rev_cnt;
   logic       locked;
   logic       fault;
   logic [1:0] err_cnt;

   ring_phase_monitor #(.N(4), .LOCK_CNT(3), .REV_W(8), .ERR_W(2)) dut (
      .clk(clk), .rst(rst), .count_in(count_in), .clr_err(clr_err),
      .phase(phase), .phase_vld(phase_vld), .wrap(wrap), .rev_cnt(rev_cnt),
      .locked(locked), .fault(fault), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int phase; int vld; int wrap; int rev; int locked; int fault; int err;
   } exp_t;

   exp_t sb[$];
   int n_pass  = 0;
   int n_total = 0;
   int n_wrap  = 0;
   int n_step  = 0;

   // Reference model state: m_state 0=SYNC 1=LOCKED 2=FAULT
   int   m_state = 0, m_gr = 0, m_rev = 0, m_err = 0, m_phase = 0;
   logic [3:0] m_prev = 4'b0;
   bit   m_prev_ok = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_state = 0; m_gr = 0; m_rev = 0; m_err = 0; m_phase = 0;
      m_prev = 4'b0; m_prev_ok = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] cin, input logic clr);
      bit oh, lg, wr;
      logic [3:0] want;
      exp_t e;
      oh   = ($countones(cin) == 1);
      want = {m_prev[2:0], m_prev[3]};
      lg   = oh && m_prev_ok && (cin == want);
      wr   = 1'b0;
      if (oh) for (int i = 0; i < 4; i++) if (cin[i]) m_phase = i;
      case (m_state)
         0: begin
            if (clr) m_err = 0;
            if (lg) begin
               m_gr++;
               if (m_gr == 3) begin m_state = 1; m_gr = 0; end
            end else m_gr = 0;
         end
         1: begin
            if (clr) m_err = 0;
            if (lg) begin
               if (cin[0]) begin wr = 1'b1; m_rev = (m_rev + 1) % 256; end
            end else begin
               m_state = 2;
               m_err = (m_err < 3) ? m_err + 1 : 3;
            end
         end
         default: begin
            if (clr) begin m_state = 0; m_gr = 0; m_err = 0; end
            else if (!lg) m_err = (m_err < 3) ? m_err + 1 : 3;
         end
      endcase
      m_prev = cin; m_prev_ok = oh;
      e.phase = m_phase; e.vld = oh; e.wrap = wr; e.rev = m_rev;
      e.locked = (m_state == 1); e.fault = (m_state == 2); e.err = m_err;
      sb.push_back(e);
   endtask

   // Drive one sample at the falling edge, compare just after the rising edge.
   task automatic step(input logic [3:0] cin, input logic clr);
      exp_t e;
      count_in = cin;
      clr_err  = clr;
      model_step(cin, clr);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("phase",     32'(phase),     e.phase);
      check("phase_vld", 32'(phase_vld), e.vld);
      check("wrap",      32'(wrap),      e.wrap);
      check("rev_cnt",   32'(rev_cnt),   e.rev);
      check("locked",    32'(locked),    e.locked);
      check("fault",     32'(fault),     e.fault);
      check("err_cnt",   32'(err_cnt),   e.err);
      if (wrap === 1'b1) n_wrap++;
      n_step++;
      $display("step %0d in=%b clr=%b phase=%0d vld=%b wrap=%b rev=%0d lk=%b flt=%b err=%0d",
               n_step, cin, clr, phase, phase_vld, wrap, rev_cnt, locked, fault, err_cnt);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_phase"},  32'(phase),     0);
      check({tag, "_vld"},    32'(phase_vld), 0);
      check({tag, "_wrap"},   32'(wrap),      0);
      check({tag, "_rev"},    32'(rev_cnt),   0);
      check({tag, "_locked"}, 32'(locked),    0);
      check({tag, "_fault"},  32'(fault),     0);
      check({tag, "_err"},    32'(err_cnt),   0);
   endtask

   initial begin
      logic [3:0] v;
      rst = 1'b0; count_in = 4'b0; clr_err = 1'b0;
      #2;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // 1: first revolution, lock after 1000, wrap at the closing 0001
      step(4'b0001, 0); step(4'b0010, 0); step(4'b0100, 0); step(4'b1000, 0);
      check("t1_locked", 32'(locked), 1);
      step(4'b0001, 0);
      check("t1_rev", 32'(rev_cnt), 1);

      // 2: invalid pattern while locked
      step(4'b0010, 0); step(4'b0100, 0); step(4'b1000, 0); step(4'b0011, 0);
      check("t2_phase_hold", 32'(phase), 3);
      check("t2_vld", 32'(phase_vld), 0);
      check("t2_fault", 32'(fault), 1);
      check("t2_err", 32'(err_cnt), 1);

      // 3: clear, relock, then skip and hold
      step(4'b0001, 1);
      step(4'b0010, 0); step(4'b0100, 0); step(4'b1000, 0); step(4'b0001, 0);
      step(4'b0100, 0); step(4'b0100, 0);
      check("t3_err", 32'(err_cnt), 2);

      // 4: saturation, clear colliding with an illegal sample, relock
      step(4'b0100, 0); step(4'b0000, 0); step(4'b1111, 0); step(4'b0100, 0);
      check("t4_sat", 32'(err_cnt), 3);
      step(4'b0110, 1);
      check("t4_clr_fault", 32'(fault), 0);
      check("t4_clr_err", 32'(err_cnt), 0);
      step(4'b0001, 0); step(4'b0010, 0); step(4'b0100, 0); step(4'b1000, 0);
      check("t4_relock", 32'(locked), 1);

      // 5: asynchronous reset mid-revolution
      step(4'b0001, 0); step(4'b0010, 0);
      rst = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      step(4'b0001, 0); step(4'b0010, 0); step(4'b0100, 0); step(4'b1000, 0);
      check("t5_relock", 32'(locked), 1);
      check("t5_rev", 32'(rev_cnt), 0);

      // 6: 256 revolutions wrap rev_cnt back to 0
      n_wrap = 0;
      for (int r = 0; r < 256; r++) begin
         for (int k = 0; k < 4; k++) begin
            v = 4'b0001 << k;
            step(v, 0);
         end
      end
      check("t6_wrap_total", n_wrap, 256);
      check("t6_rev", 32'(rev_cnt), 0);

      // clr_err with an illegal hold while locked: fault with err_cnt=1
      step(4'b1000, 1);
      check("clr_locked_fault", 32'(fault), 1);
      check("clr_locked_err", 32'(err_cnt), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
